// File: rtl/udp_frame_gen.sv
// udp_frame_gen: per-beat byte generator for one Ethernet/IPv4/UDP video frame (no preamble/FCS)
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                frame request, latched into a pending flag while idle
//   advance              byte beat from the transmitter; all frame state moves only on these beats
//   index_clone          clone id, captured at launch
//   startaddr            first pixel address, captured at launch
//   vramdata             VRAM read data, RD_LAT beats behind vramaddr/vramaddr_c
//   vramaddr/vramaddr_c  VRAM pixel address and RGB component selector
//   lastaddr             last pixel sent in the previous frame (0 if the frame wrapped)
//   busy                 frame in progress
//   data/data_valid/data_user  registered frame byte, in-frame flag, payload flag
//   data_enable          registered copy of advance
//   done                 one-cycle pulse at the end of the inter-frame gap
// Build option: define UDP_FRAME_GEN_SEQ_EN to append a 16-bit frame sequence number to the stream header.
module udp_frame_gen #(
    parameter int          PAYLOAD_BYTES = 1440,
    parameter int          IFG_BEATS     = 22,
    parameter int          ADDR_W        = 20,
    parameter int          MAX_ADDR      = 57599,
    parameter int          RD_LAT        = 2,
    parameter logic [47:0] SRC_MAC       = 48'hdeadbeef0123,
    parameter logic [47:0] DST_MAC       = 48'hffffffffffff,
    parameter logic [31:0] SRC_IP        = 32'hc0a80140,
    parameter logic [31:0] DST_IP        = 32'hc0a80102,
    parameter logic [15:0] UDP_PORT      = 16'h1000,
    parameter logic [7:0]  TTL           = 8'h10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              advance,
    input  logic [7:0]        index_clone,
    input  logic [ADDR_W-1:0] startaddr,
    input  logic [7:0]        vramdata,
    output logic [ADDR_W-1:0] vramaddr,
    output logic [1:0]        vramaddr_c,
    output logic [ADDR_W-1:0] lastaddr,
    output logic              busy,
    output logic [7:0]        data,
    output logic              data_valid,
    output logic              data_user,
    output logic              data_enable,
    output logic              done
);
`ifdef UDP_FRAME_GEN_SEQ_EN
    localparam int H = 6;
`else
    localparam int H = 4;
`endif
    localparam int HDR_BYTES   = 42 + H;
    localparam int HDR_W       = HDR_BYTES * 8;
    localparam int FRAME_BYTES = HDR_BYTES + PAYLOAD_BYTES;
    // address issue runs RD_LAT beats ahead of the byte that consumes it
    localparam int ISS_FIRST   = HDR_BYTES - RD_LAT;
    localparam int ISS_LAST    = ISS_FIRST + PAYLOAD_BYTES - 1;
    localparam logic [15:0] UDP_LEN = 16'(8 + H + PAYLOAD_BYTES);
    localparam logic [15:0] IP_LEN  = 16'(28 + H + PAYLOAD_BYTES);
    localparam logic [ADDR_W-1:0] LAST_OFS = ADDR_W'(PAYLOAD_BYTES / 3 - 1);
    localparam logic [ADDR_W-1:0] MAX_A    = ADDR_W'(MAX_ADDR);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, GAP} state_t;
    state_t state, state_n;

    logic              pending, wrap, launch, done_n, step;
    logic [15:0]       cnt, gcnt, ip_id, csum, csum_n;
    logic [19:0]       csum_acc, csum_f1;
    logic [7:0]        index_r, hdr_byte;
    logic [ADDR_W-1:0] sa;
    logic [19:0]       sa20;
    logic [5:0]        hidx;
    logic [RD_LAT-1:0] wrap_d;
    logic [HDR_W-1:0]  hdr;
`ifdef UDP_FRAME_GEN_SEQ_EN
    logic [15:0]       seq;
`endif

    assign busy = state != IDLE;
    assign sa20 = 20'(sa);

    // ones-complement sum of the IP header words with the checksum field as zero
    assign csum_acc = 20'h04500 + 20'(IP_LEN) + 20'(ip_id) + 20'({TTL, 8'h11})
                    + 20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0]) + 20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);
    assign csum_f1  = 20'(csum_acc[15:0]) + 20'(csum_acc[19:16]);
    assign csum_n   = ~(csum_f1[15:0] + 16'(csum_f1[19:16]));

    assign hdr = {DST_MAC, SRC_MAC, 16'h0800,
                  16'h4500, IP_LEN, ip_id, 16'h0000, TTL, 8'h11, csum, SRC_IP, DST_IP,
                  UDP_PORT, UDP_PORT, UDP_LEN, 16'h0000,
                  index_r, 4'h0, sa20
`ifdef UDP_FRAME_GEN_SEQ_EN
                  , seq
`endif
                  };
    assign hidx     = (cnt < 16'(HDR_BYTES)) ? cnt[5:0] : 6'd0;
    assign hdr_byte = hdr[(HDR_BYTES - 1 - int'(hidx)) * 8 +: 8];

    assign step = (state == HDR || state == PAYLOAD) && !wrap
                  && cnt >= 16'(ISS_FIRST) && cnt < 16'(ISS_LAST);

    always_comb begin
        state_n = state;
        launch  = 1'b0;
        if (advance)
            case (state)
                IDLE:    if (pending) begin state_n = HDR; launch = 1'b1; end
                HDR:     if (cnt == 16'(HDR_BYTES - 1)) state_n = PAYLOAD;
                PAYLOAD: if (cnt == 16'(FRAME_BYTES - 1)) state_n = GAP;
                GAP:     if (gcnt == 16'(IFG_BEATS - 1)) state_n = IDLE;
            endcase
    end

    assign done_n = advance && state == GAP && state_n == IDLE;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= 1'b0;
            wrap        <= 1'b0;
            wrap_d      <= '0;
            cnt         <= '0;
            gcnt        <= '0;
            ip_id       <= '0;
            csum        <= '0;
            index_r     <= '0;
            sa          <= '0;
            vramaddr    <= '0;
            vramaddr_c  <= '0;
            lastaddr    <= '0;
            data        <= '0;
            data_valid  <= 1'b0;
            data_user   <= 1'b0;
            data_enable <= 1'b0;
            done        <= 1'b0;
`ifdef UDP_FRAME_GEN_SEQ_EN
            seq         <= '0;
`endif
        end else begin
            data_enable <= advance;
            done        <= done_n;
            pending     <= launch ? 1'b0 : (pending | (start && state == IDLE));
            if (advance) begin
                // wrap state travels with each address so the matching byte is zeroed
                wrap_d     <= RD_LAT'({wrap_d, wrap});
                data       <= 8'h00;
                data_valid <= 1'b0;
                data_user  <= 1'b0;
                if (launch) begin
                    cnt        <= '0;
                    gcnt       <= '0;
                    wrap       <= 1'b0;
                    index_r    <= index_clone;
                    sa         <= startaddr;
                    vramaddr   <= startaddr;
                    vramaddr_c <= '0;
                    csum       <= csum_n;
                end
                if (state == HDR || state == PAYLOAD) begin
                    cnt        <= cnt + 16'd1;
                    data_valid <= 1'b1;
                    data_user  <= state == PAYLOAD;
                    data       <= state == HDR ? hdr_byte : (wrap_d[RD_LAT-1] ? 8'h00 : vramdata);
                    if (state_n == GAP) lastaddr <= wrap ? '0 : sa + LAST_OFS;
                end
                if (step) begin
                    vramaddr_c <= vramaddr_c == 2'd2 ? 2'd0 : vramaddr_c + 2'd1;
                    if (vramaddr_c == 2'd2) begin
                        vramaddr <= vramaddr == MAX_A ? '0 : vramaddr + 1'b1;
                        wrap     <= vramaddr == MAX_A;
                    end
                end
                if (state == GAP) gcnt <= gcnt + 16'd1;
                if (done_n) begin
                    ip_id <= ip_id + 16'd1;
`ifdef UDP_FRAME_GEN_SEQ_EN
                    seq   <= seq + 16'd1;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_udp_frame_gen.sv
// tb_udp_frame_gen: random-advance frame checks of udp_frame_gen against a byte-list reference model
module tb_udp_frame_gen;
    localparam int P        = 1440;
    localparam int IFG      = 22;
    localparam int RD_LAT   = 2;
    localparam int MAX_ADDR = 57599;
`ifdef UDP_FRAME_GEN_SEQ_EN
    localparam int H = 6;
    localparam logic [15:0] CSUM0 = 16'h2199;
    localparam logic [15:0] CSUM1 = 16'h2198;
`else
    localparam int H = 4;
    localparam logic [15:0] CSUM0 = 16'h219b;
    localparam logic [15:0] CSUM1 = 16'h219a;
`endif
    localparam int N = 42 + H + P;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, advance = 1'b0;
    logic [7:0]  index_clone = '0, vramdata, data;
    logic [19:0] startaddr = '0, vramaddr, lastaddr;
    logic [1:0]  vramaddr_c;
    logic        busy, data_valid, data_user, data_enable, done;

    udp_frame_gen #(.PAYLOAD_BYTES(P), .IFG_BEATS(IFG), .RD_LAT(RD_LAT), .MAX_ADDR(MAX_ADDR)) dut (
        .clk(clk), .rst(rst), .start(start), .advance(advance), .index_clone(index_clone),
        .startaddr(startaddr), .vramdata(vramdata), .vramaddr(vramaddr), .vramaddr_c(vramaddr_c),
        .lastaddr(lastaddr), .busy(busy), .data(data), .data_valid(data_valid), .data_user(data_user),
        .data_enable(data_enable), .done(done)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    logic [15:0] id_m = '0, seq_m = '0;
    logic [8:0]  exp_q[$], got_q[$];
    logic [19:0] pa [RD_LAT] = '{default: '0};
    logic [1:0]  pc [RD_LAT] = '{default: '0};

    function automatic logic [7:0] vb(input logic [19:0] a, input logic [1:0] c);
        return 8'(32'(a) * 5 + 32'(c) * 77 + 32'(a >> 8)) ^ 8'h5a;
    endfunction

    // VRAM with a read latency of RD_LAT advance beats
    assign vramdata = vb(pa[RD_LAT-1], pc[RD_LAT-1]);
    always @(posedge clk)
        if (advance) begin
            pa[0] <= vramaddr;
            pc[0] <= vramaddr_c;
            for (int i = 1; i < RD_LAT; i++) begin
                pa[i] <= pa[i-1];
                pc[i] <= pc[i-1];
            end
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ip_csum(input logic [15:0] id);
        logic [15:0] w [10];
        int s = 0;
        w = '{16'h4500, 16'(28 + H + P), id, 16'h0, 16'h1011, 16'h0, 16'hc0a8, 16'h0140, 16'hc0a8, 16'h0102};
        foreach (w[i]) s += int'(w[i]);
        while (s > 32'hffff) s = (s & 32'hffff) + (s >> 16);
        return ~16'(s);
    endfunction

    function automatic void push8(input logic u, input logic [7:0] b);
        exp_q.push_back({u, b});
    endfunction

    function automatic void push16(input logic [15:0] w);
        push8(1'b0, w[15:8]);
        push8(1'b0, w[7:0]);
    endfunction

    function automatic void build(input logic [19:0] sa, input logic [7:0] ic);
        int pix;
        exp_q.delete();
        push16(16'hffff); push16(16'hffff); push16(16'hffff);
        push16(16'hdead); push16(16'hbeef); push16(16'h0123); push16(16'h0800);
        push16(16'h4500); push16(16'(28 + H + P)); push16(id_m); push16(16'h0); push16(16'h1011);
        push16(ip_csum(id_m)); push16(16'hc0a8); push16(16'h0140); push16(16'hc0a8); push16(16'h0102);
        push16(16'h1000); push16(16'h1000); push16(16'(8 + H + P)); push16(16'h0);
        push8(1'b0, ic); push8(1'b0, {4'h0, sa[19:16]}); push16(sa[15:0]);
`ifdef UDP_FRAME_GEN_SEQ_EN
        push16(seq_m);
`endif
        for (int i = 0; i < P; i++) begin
            pix = int'(sa) + i / 3;
            push8(1'b1, pix > MAX_ADDR ? 8'h00 : vb(20'(pix), 2'(i % 3)));
        end
    endfunction

    task automatic run_frame(input logic [19:0] sa, input logic [7:0] ic, input int abort_at);
        int gap = 0, ndone = 0, extra = 0, last;
        logic aborted = 1'b0;
        build(sa, ic);
        got_q.delete();
        @(negedge clk);
        startaddr = sa; index_clone = ic; start = 1'b1; advance = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 12000 && ndone == 0; cyc++) begin
            advance = $urandom_range(0, 3) != 0;
            start = cyc == 700;
            @(negedge clk);
            if (cyc == 700) check("busy_mid", busy, 1);
            if (data_enable && data_valid) got_q.push_back({data_user, data});
            if (data_enable && !data_valid && got_q.size() > 0) gap++;
            if (done) ndone++;
            if (abort_at >= 0 && got_q.size() == 42 + H + abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("abort_valid", data_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_lastaddr", lastaddr, 0);
                id_m = '0;
                seq_m = '0;
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            check("valid_beats", got_q.size(), N);
            for (int i = 0; i < N && i < got_q.size(); i++) check($sformatf("byte%0d", i), got_q[i], exp_q[i]);
            check("gap_beats", gap, IFG);
            check("done_count", ndone, 1);
            check("busy_end", busy, 0);
            last = int'(sa) + P / 3 - 1;
            check("lastaddr", lastaddr, last > MAX_ADDR ? 0 : last);
            check("vramaddr", vramaddr, last > MAX_ADDR ? 0 : last);
            check("vramaddr_c", vramaddr_c, last > MAX_ADDR ? 0 : 2);
            id_m++;
            seq_m++;
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            advance = $urandom_range(0, 1) != 0;
            @(negedge clk);
            if (done) extra++;
        end
        check("no_extra_done", extra, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_valid", data_valid, 0);
        check("rst_user", data_user, 0);
        check("rst_data", data, 0);
        check("rst_done", done, 0);
        check("rst_enable", data_enable, 0);
        check("rst_lastaddr", lastaddr, 0);
        check("rst_vramaddr", {vramaddr, vramaddr_c}, 0);
        rst = 1'b0;
        advance = 1'b1;
        repeat (10) @(negedge clk);
        check("start_during_rst", busy, 0);
        check("enable_copy", data_enable, 1);
        run_frame(20'd0, 8'h03, -1);
        check("ip_len", {got_q[16][7:0], got_q[17][7:0]}, 16'(28 + H + P));
        check("udp_len", {got_q[38][7:0], got_q[39][7:0]}, 16'(8 + H + P));
        check("csum0", {got_q[24][7:0], got_q[25][7:0]}, CSUM0);
        check("lastaddr479", lastaddr, 479);
        run_frame(20'd0, 8'h55, -1);
        check("ip_id1", {got_q[18][7:0], got_q[19][7:0]}, 16'h0001);
        check("csum1", {got_q[24][7:0], got_q[25][7:0]}, CSUM1);
        run_frame(20'd57590, 8'h07, -1);
        check("wrap_zero", got_q[42 + H + 30], 9'h100);
        run_frame(20'($urandom_range(0, MAX_ADDR)), 8'($urandom), -1);
        run_frame(20'd1234, 8'h11, 100);
        run_frame(20'd777, 8'h22, -1);
        check("ip_id_after_rst", {got_q[18][7:0], got_q[19][7:0]}, 16'h0000);
        check("csum_after_rst", {got_q[24][7:0], got_q[25][7:0]}, CSUM0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/udp_frame_gen.md
# udp_frame_gen

Parametrised per-beat byte generator for one Ethernet/IPv4/UDP video frame, without preamble or FCS. It emits the header, a custom stream header (clone index, start address, optional sequence number) and a payload read from VRAM as RGB byte triplets. Each frame ends with a programmable idle gap. It sits between the VRAM read port and the nibble/CRC transmitter, which supplies `advance` beats. Over a fixed byte generator, it adds parametrised addressing and lengths, a per-frame IP identification with a runtime checksum, zero-padding on address wrap, and abort on reset.

## Interface
- `PAYLOAD_BYTES`, 1440: VRAM bytes per frame; must be a multiple of 3.
- `IFG_BEATS`, 22: idle beats after the last valid byte, before returning to IDLE.
- `ADDR_W`, 20: VRAM pixel address width.
- `MAX_ADDR`, 57599: last valid pixel address (320×180 − 1).
- `RD_LAT`, 2: VRAM read latency in `advance` beats, range 1–3.
- `SRC_MAC`, 48'hdeadbeef0123; `DST_MAC`, 48'hffffffffffff.
- `SRC_IP`, 32'hc0a80140; `DST_IP`, 32'hc0a80102.
- `UDP_PORT`, 16'h1000: used as both source and destination port.
- `TTL`, 8'h10.
- `clk` in 1: the block's only clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: frame request.
- `advance` in 1: one byte beat.
- `index_clone` in 8: clone ID, captured at frame launch.
- `startaddr` in ADDR_W: first pixel address, captured at frame launch.
- `vramdata` in 8: VRAM read data.
- `vramaddr` out ADDR_W: VRAM pixel address.
- `vramaddr_c` out 2: RGB component selector, 0..2.
- `lastaddr` out ADDR_W: last pixel sent in the previous frame.
- `busy` out 1: frame in progress.
- `data` out 8: byte for the current beat.
- `data_valid` out 1: byte is part of the frame.
- `data_user` out 1: byte is VRAM payload.
- `data_enable` out 1: registered copy of `advance`.
- `done` out 1: one-cycle pulse at the end of the gap.

## Operation
- States: IDLE → HDR → PAYLOAD → GAP → IDLE.
- **HDR = ETH + IP + UDP + custom header.**
  - ETH, 14 bytes: `DST_MAC`, `SRC_MAC`, 0x0800.
  - IP, 20 bytes: 45, 00, ip_len, ip_id, 0000, `TTL`, 11, checksum, `SRC_IP`, `DST_IP`.
  - UDP, 8 bytes: `UDP_PORT`, `UDP_PORT`, udp_len, 0000.
  - Custom header, H bytes (H=4): `index_clone`, {4'b0, `startaddr`[19:16]}, `startaddr`[15:8], `startaddr`[7:0]. The startaddr bytes are zero-extended or truncated to 20 bits.
- **Lengths.** udp_len = 8 + H + `PAYLOAD_BYTES`; ip_len = 20 + udp_len. Defaults: 1452 and 1472.
- All multi-byte fields are sent MSB first.
- **Launch.**
  - A `start` pulse in IDLE sets a pending flag.
  - The next `advance` beat with the flag set captures `index_clone` and `startaddr` and enters HDR. `busy` rises on that clk.
  - `start` while `busy`=1 is ignored.
- **Checksum.**
  - Sum the ten 16-bit IP header words, using the current ip_id, in a 20-bit accumulator.
  - Fold the carry into the low 16 bits twice, then invert.
  - The result must be registered at launch, ahead of IP byte 10.
- **ip_id.** 16-bit, starts at 0, increments by 1 at each `done`, wraps 0xFFFF→0.
- **Payload addressing.**
  - Each beat steps `vramaddr_c` 0→1→2; on the step from 2 it returns to 0 and `vramaddr` increments.
  - `vramaddr` = `startaddr` with `vramaddr_c`=0 is presented `RD_LAT` beats before the first payload byte.
  - `vramdata` is sampled on the beat that emits each payload byte.
- **Address wrap.**
  - After the component-2 address of `MAX_ADDR` has been issued, set a wrap flag and hold `vramaddr` and `vramaddr_c` at 0.
  - Remaining payload bytes are 8'h00, with `data_user` still 1.
- **lastaddr.** Updated on the last payload beat:
  - 0 if the wrap flag is set;
  - otherwise the pixel address of the last payload byte, i.e. `startaddr` + `PAYLOAD_BYTES`/3 − 1.
- **GAP.** `IFG_BEATS` beats with `data`=0 and `data_valid`=0, then `done` pulses, `busy` falls and the state returns to IDLE.

## Timing
- Every state, counter and output updates only on clk edges where `advance`=1. Exceptions, which update on every clk: `start` pending capture, `data_enable`, `done`.
- `data`, `data_valid` and `data_user` are registered and change on the clk edge that samples `advance`.
- Byte k of the frame is present from beat k+1 of HDR/PAYLOAD until the next beat.
- `data_valid`:
  - rises with the first DST_MAC byte;
  - falls on the beat after the last payload byte;
  - is high for exactly 42 + H + `PAYLOAD_BYTES` beats (1486 by default).
- `data_user` rises with the first payload byte and falls together with `data_valid`.
- Minimum start-to-start period: 42 + H + `PAYLOAD_BYTES` + `IFG_BEATS` + 1 beats.
- **Reset values.**
  - 0: all outputs, ip_id, wrap flag, pending flag.
  - State: IDLE.
- **Reset mid-frame.** Aborts the frame; outputs are 0 on the next clk, and no `done` is issued.
- **`start` and `rst` in the same cycle.** `rst` wins.

## Configuration
- `UDP_FRAME_GEN_SEQ_EN`:
  - **Defined:** H=6. Custom header bytes 5–6 carry a 16-bit frame sequence number, MSB first. It is a separate counter from ip_id, increments at `done`, and is reset to 0. udp_len and ip_len grow by 2 (defaults 1454 and 1474); the checksum follows.
  - **Not defined:** H=4 and no sequence counter exists.

## Test plan
- **First frame, default parameters (macro off).** `rst`, then `start` with `advance` every 2 clk, `startaddr`=0, `index_clone`=8'h03.
  - Bytes 0–13: ff×6, de ad be ef 01 23, 08 00.
  - IP length 05 c0; checksum 21 9b.
  - Custom header 03 00 00 00.
  - 1440 payload bytes match VRAM[0..479].
  - `lastaddr`=479; `done` once.
- **Back-to-back frames.** Second frame has ip_id=0001 and checksum 21 9a. `start` pulsed mid-frame has no effect.
- **Wrap.** `startaddr`=57590.
  - 30 payload bytes from addresses 57590..57599, then 1410 bytes of 00.
  - `lastaddr`=0; `vramaddr` held at 0.
- **Latency.** Repeat the first-frame test with `RD_LAT`=3 and a VRAM model with matching latency → payload is identical.
- **Reset mid-payload.** Assert `rst` at payload beat 100 → next clk `data_valid`=0 and `busy`=0, no `done`. A subsequent `start` sends a full frame with ip_id=0000.
- **Macro on.**
  - udp_len 05 ae, ip_len 05 c2.
  - Sequence bytes 00 00, then 00 01 in the next frame.
  - `data_valid` high for 1488 beats.
